// File: rtl/cmp_nic_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmp_nic_arb_pkg                                            |
// | Description : Shared types and constants for the two-core NIC arbiter:   |
// |               FSM state encoding, default NIC widths and core indices.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cmp_nic_arb_pkg;

  // Default NIC register-port widths
  localparam int DATA_W_DEFAULT     = 64;
  localparam int NIC_ADDR_W_DEFAULT = 2;

  // Core indices, also used as the pointer / winner / lock-owner encoding
  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

  // One NIC access per grant: register fields, strobe, collect data, complete
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage : cmp_nic_arb_pkg
`default_nettype wire

// File: rtl/cmp_nic_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmp_nic_rr_pick                                            |
// | Description : Combinational two-way round-robin picker. A lone requester |
// |               wins; on contention the core named by ptr wins. With       |
// |               CMP_NIC_ARB_LOCK_EN defined, a valid lock owner is the     |
// |               only core that may be granted.                             |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Ports                                                                    |
// |   req         in  [1:0] request per core (bit k = core k)                |
// |   ptr         in        priority pointer (core favoured on contention)   |
// |   lock_owner  in        current lock owner   (CMP_NIC_ARB_LOCK_EN only)  |
// |   lock_valid  in        lock owner is active (CMP_NIC_ARB_LOCK_EN only)  |
// |   winner      out       granted core index                               |
// |   grant_valid out       a grant is made this cycle                       |
// +--------------------------------------------------------------------------+
module cmp_nic_rr_pick
  import cmp_nic_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
`ifdef CMP_NIC_ARB_LOCK_EN
  input  logic       lock_owner,
  input  logic       lock_valid,
`endif
  output logic       winner,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    winner      = CORE0;
    if (req == 2'b11) begin
      winner = ptr;
    end else if (req[CORE1]) begin
      winner = CORE1;
    end
`ifdef CMP_NIC_ARB_LOCK_EN
    // An owned NIC is granted only to its owner; the other core simply waits
    if (lock_valid) begin
      winner      = lock_owner;
      grant_valid = req[lock_owner];
    end
`endif
  end

endmodule : cmp_nic_rr_pick
`default_nettype wire

// File: rtl/cmp_nic_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmp_nic_arbiter                                            |
// | Description : Shares one NIC register port between two cores. Grants    |
// |               round-robin, performs one NIC access per grant and returns |
// |               a one-cycle done pulse (plus read data) to the winner.     |
// |               Optional feature macro: CMP_NIC_ARB_LOCK_EN (lock ports).  |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Ports                                                                    |
// |   clk, reset               clock, asynchronous active-low reset          |
// |   cX_nicEn/nicWrEn         core request / write(1) read(0)               |
// |   cX_addr_nic/din_nic      core address / write data                     |
// |   cX_lock                  hold ownership (CMP_NIC_ARB_LOCK_EN only)     |
// |   cX_dout_nic/done         core read data / completion pulse             |
// |   nicEn/nicWrEn/addr_nic/din_nic  NIC command outputs                    |
// |   dout_nic                 NIC read data (valid cycle after nicEn)       |
// +--------------------------------------------------------------------------+
module cmp_nic_arbiter
  import cmp_nic_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int NIC_ADDR_W = NIC_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef CMP_NIC_ARB_LOCK_EN
  input  logic                  c0_lock,
  input  logic                  c1_lock,
`endif
  input  logic                  c0_nicEn,
  input  logic                  c0_nicWrEn,
  input  logic [0:NIC_ADDR_W-1] c0_addr_nic,
  input  logic [0:DATA_W-1]     c0_din_nic,
  output logic [0:DATA_W-1]     c0_dout_nic,
  output logic                  c0_done,
  input  logic                  c1_nicEn,
  input  logic                  c1_nicWrEn,
  input  logic [0:NIC_ADDR_W-1] c1_addr_nic,
  input  logic [0:DATA_W-1]     c1_din_nic,
  output logic [0:DATA_W-1]     c1_dout_nic,
  output logic                  c1_done,
  output logic                  nicEn,
  output logic                  nicWrEn,
  output logic [0:NIC_ADDR_W-1] addr_nic,
  output logic [0:DATA_W-1]     din_nic,
  input  logic [0:DATA_W-1]     dout_nic
);

  arb_state_t              r_state;
  logic                    r_ptr;
  logic                    r_winner;
  logic                    r_nic_en;
  logic                    r_nic_wr_en;
  logic [0:NIC_ADDR_W-1]   r_addr;
  logic [0:DATA_W-1]       r_din;
  logic                    r_c0_done;
  logic                    r_c1_done;
  logic [0:DATA_W-1]       r_c0_dout;
  logic [0:DATA_W-1]       r_c1_dout;

  logic [1:0]              w_req;
  logic                    w_winner;
  logic                    w_grant_valid;

  assign w_req = {c1_nicEn, c0_nicEn};

`ifdef CMP_NIC_ARB_LOCK_EN
  logic r_lock_owner;
  logic r_lock_valid;
  logic r_lock_req;   // lock bit presented with the access in flight
  logic w_lock;

  assign w_lock = (w_winner == CORE1) ? c1_lock : c0_lock;
`endif

  cmp_nic_rr_pick u_pick (
    .req         (w_req),
    .ptr         (r_ptr),
`ifdef CMP_NIC_ARB_LOCK_EN
    .lock_owner  (r_lock_owner),
    .lock_valid  (r_lock_valid),
`endif
    .winner      (w_winner),
    .grant_valid (w_grant_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ptr        <= CORE0;
      r_winner     <= CORE0;
      r_nic_en     <= 1'b0;
      r_nic_wr_en  <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_c0_done    <= 1'b0;
      r_c1_done    <= 1'b0;
      r_c0_dout    <= '0;
      r_c1_dout    <= '0;
`ifdef CMP_NIC_ARB_LOCK_EN
      r_lock_owner <= CORE0;
      r_lock_valid <= 1'b0;
      r_lock_req   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_winner    <= w_winner;
            r_nic_en    <= 1'b1;
            r_nic_wr_en <= (w_winner == CORE1) ? c1_nicWrEn  : c0_nicWrEn;
            r_addr      <= (w_winner == CORE1) ? c1_addr_nic : c0_addr_nic;
            r_din       <= (w_winner == CORE1) ? c1_din_nic  : c0_din_nic;
`ifdef CMP_NIC_ARB_LOCK_EN
            r_lock_req  <= w_lock;
            if (w_lock) begin
              r_lock_owner <= w_winner;
              r_lock_valid <= 1'b1;
            end
`endif
            r_state     <= CMD;
          end
        end
        CMD: begin
          r_nic_en <= 1'b0;
          r_state  <= DATA;
        end
        DATA: begin
          // NIC data is valid now; done is raised here so it is high in DONE
          if (!r_nic_wr_en) begin
            if (r_winner == CORE1) r_c1_dout <= dout_nic;
            else                   r_c0_dout <= dout_nic;
          end
          r_c0_done <= (r_winner == CORE0);
          r_c1_done <= (r_winner == CORE1);
          r_state   <= DONE;
        end
        DONE: begin
          r_c0_done <= 1'b0;
          r_c1_done <= 1'b0;
          r_ptr     <= ~r_winner;
`ifdef CMP_NIC_ARB_LOCK_EN
          // An owner access issued without lock releases ownership
          if (r_lock_valid && (r_lock_owner == r_winner) && !r_lock_req) begin
            r_lock_valid <= 1'b0;
          end
`endif
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign nicEn       = r_nic_en;
  assign nicWrEn     = r_nic_wr_en;
  assign addr_nic    = r_addr;
  assign din_nic     = r_din;
  assign c0_done     = r_c0_done;
  assign c1_done     = r_c1_done;
  assign c0_dout_nic = r_c0_dout;
  assign c1_dout_nic = r_c1_dout;

endmodule : cmp_nic_arbiter
`default_nettype wire

// File: tb/tb_cmp_nic_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cmp_nic_arbiter                                         |
// | Description : Directed self-checking bench for cmp_nic_arbiter. Inputs   |
// |               change and outputs are sampled 1 time unit after the       |
// |               rising edge. Lock scenario runs when CMP_NIC_ARB_LOCK_EN   |
// |               is defined.                                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cmp_nic_arbiter;

  logic        clk;
  logic        reset;
  logic        c0_nicEn, c0_nicWrEn, c1_nicEn, c1_nicWrEn;
  logic [0:1]  c0_addr_nic, c1_addr_nic, addr_nic;
  logic [0:63] c0_din_nic, c1_din_nic, c0_dout_nic, c1_dout_nic;
  logic        c0_done, c1_done;
  logic        nicEn, nicWrEn;
  logic [0:63] din_nic, dout_nic;
`ifdef CMP_NIC_ARB_LOCK_EN
  logic        c0_lock, c1_lock;
`endif

  int n_cmp;
  int n_bad;

  cmp_nic_arbiter #(.DATA_W(64), .NIC_ADDR_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef CMP_NIC_ARB_LOCK_EN
    .c0_lock     (c0_lock),
    .c1_lock     (c1_lock),
`endif
    .c0_nicEn    (c0_nicEn),
    .c0_nicWrEn  (c0_nicWrEn),
    .c0_addr_nic (c0_addr_nic),
    .c0_din_nic  (c0_din_nic),
    .c0_dout_nic (c0_dout_nic),
    .c0_done     (c0_done),
    .c1_nicEn    (c1_nicEn),
    .c1_nicWrEn  (c1_nicWrEn),
    .c1_addr_nic (c1_addr_nic),
    .c1_din_nic  (c1_din_nic),
    .c1_dout_nic (c1_dout_nic),
    .c1_done     (c1_done),
    .nicEn       (nicEn),
    .nicWrEn     (nicWrEn),
    .addr_nic    (addr_nic),
    .din_nic     (din_nic),
    .dout_nic    (dout_nic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    c0_nicEn = 0; c0_nicWrEn = 0; c0_addr_nic = '0; c0_din_nic = '0;
    c1_nicEn = 0; c1_nicWrEn = 0; c1_addr_nic = '0; c1_din_nic = '0;
    dout_nic = '0;
`ifdef CMP_NIC_ARB_LOCK_EN
    c0_lock = 0; c1_lock = 0;
`endif
    tick(); tick();

    // ---- reset state
    check_eq("rst_nicEn",   {63'd0, nicEn},   64'd0);
    check_eq("rst_nicWrEn", {63'd0, nicWrEn}, 64'd0);
    check_eq("rst_addr",    {62'd0, addr_nic}, 64'd0);
    check_eq("rst_din",     din_nic,           64'd0);
    check_eq("rst_done",    {62'd0, c1_done, c0_done}, 64'd0);
    check_eq("rst_dout0",   c0_dout_nic, 64'd0);
    check_eq("rst_dout1",   c1_dout_nic, 64'd0);
    reset = 1'b1;
    tick();

    // ---- both request together, pointer at reset value -> core 0 first
    c0_nicEn = 1; c0_nicWrEn = 0; c0_addr_nic = 2'b00;
    c1_nicEn = 1; c1_nicWrEn = 0; c1_addr_nic = 2'b11;
    dout_nic = 64'h11;
    tick();                                                   // N+1
    check_eq("both_nicEn0", {63'd0, nicEn}, 64'd1);
    check_eq("both_addr0",  {62'd0, addr_nic}, 64'd0);
    tick(); tick();                                           // N+3
    check_eq("both_done0",  {62'd0, c1_done, c0_done}, 64'd1);
    check_eq("both_dout0",  c0_dout_nic, 64'h11);
    c0_nicEn = 0;
    dout_nic = 64'h22;
    tick();                                                   // N+4 IDLE
    check_eq("both_gap",    {63'd0, nicEn}, 64'd0);
    tick();                                                   // N+5
    check_eq("both_nicEn1", {63'd0, nicEn}, 64'd1);
    check_eq("both_addr1",  {62'd0, addr_nic}, 64'd3);
    tick(); tick();                                           // N+7
    check_eq("both_done1",  {62'd0, c1_done, c0_done}, 64'd2);
    check_eq("both_dout1",  c1_dout_nic, 64'h22);
    c1_nicEn = 0;
    tick();

    // ---- core 0 alone reads addr 01
    c0_nicEn = 1; c0_nicWrEn = 0; c0_addr_nic = 2'b01;
    tick();                                                   // N+1
    check_eq("rd_nicEn",   {63'd0, nicEn},   64'd1);
    check_eq("rd_nicWrEn", {63'd0, nicWrEn}, 64'd0);
    check_eq("rd_addr",    {62'd0, addr_nic}, 64'd1);
    dout_nic = 64'hA5;
    tick();                                                   // N+2
    check_eq("rd_nicEn_off", {63'd0, nicEn}, 64'd0);
    tick();                                                   // N+3
    check_eq("rd_done",  {62'd0, c1_done, c0_done}, 64'd1);
    check_eq("rd_dout",  c0_dout_nic, 64'hA5);
    c0_nicEn = 0;
    tick();                                                   // N+4
    check_eq("rd_done_pulse", {62'd0, c1_done, c0_done}, 64'd0);
    check_eq("rd_dout_hold",  c0_dout_nic, 64'hA5);

    // ---- core 1 writes DEAD to addr 10; its read register is untouched
    c1_nicEn = 1; c1_nicWrEn = 1; c1_addr_nic = 2'b10; c1_din_nic = 64'hDEAD;
    tick();                                                   // N+1
    check_eq("wr_nicEn", {63'd0, nicEn},   64'd1);
    check_eq("wr_wrEn",  {63'd0, nicWrEn}, 64'd1);
    check_eq("wr_addr",  {62'd0, addr_nic}, 64'd2);
    check_eq("wr_din",   din_nic, 64'hDEAD);
    dout_nic = 64'hFFFF;
    tick(); tick();                                           // N+3
    check_eq("wr_done",  {62'd0, c1_done, c0_done}, 64'd2);
    check_eq("wr_dout1", c1_dout_nic, 64'h22);
    c1_nicEn = 0; c1_nicWrEn = 0;
    tick();

    // ---- continuous contention: pointer now favours core 0
    c0_nicEn = 1; c0_addr_nic = 2'b00;
    c1_nicEn = 1; c1_addr_nic = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      logic [1:0] exp_done;
      tick();
      exp_done = 2'b00;
      if ((k % 4) == 3) exp_done = (((k / 4) % 2) == 0) ? 2'b01 : 2'b10;
      check_eq($sformatf("rr_done_k%0d", k), {62'd0, c1_done, c0_done},
               {62'd0, exp_done});
      if (k == 15) begin
        c0_nicEn = 0; c1_nicEn = 0;
      end
    end

    // ---- reset during CMD abandons the access; held request then completes
    c0_nicEn = 1; c0_nicWrEn = 0; c0_addr_nic = 2'b01;
    tick();                                                   // CMD
    check_eq("mid_nicEn", {63'd0, nicEn}, 64'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_nicEn_rst", {63'd0, nicEn}, 64'd0);
    check_eq("mid_dout_rst",  c0_dout_nic, 64'd0);
    tick();
    check_eq("mid_no_done", {62'd0, c1_done, c0_done}, 64'd0);
    reset = 1'b1;
    dout_nic = 64'h77;
    tick();
    check_eq("mid_retry_nicEn", {63'd0, nicEn}, 64'd1);
    tick(); tick();
    check_eq("mid_retry_done", {62'd0, c1_done, c0_done}, 64'd1);
    check_eq("mid_retry_dout", c0_dout_nic, 64'h77);
    c0_nicEn = 0;
    tick();

`ifdef CMP_NIC_ARB_LOCK_EN
    // ---- lock: core 0 locks, then unlocks; core 1 requests throughout
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    c0_nicEn = 1; c0_lock = 1;
    c1_nicEn = 1; c1_lock = 0;
    for (int k = 1; k <= 12; k++) begin
      logic [1:0] exp_done;
      tick();
      exp_done = 2'b00;
      if (k == 3 || k == 7) exp_done = 2'b01;
      if (k == 11)          exp_done = 2'b10;
      check_eq($sformatf("lock_done_k%0d", k), {62'd0, c1_done, c0_done},
               {62'd0, exp_done});
      if (k == 3)  c0_lock = 0;
      if (k == 7)  c0_nicEn = 0;
      if (k == 11) c1_nicEn = 0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_cmp_nic_arbiter
`default_nettype wire
